// File: rtl/axi_r_order_tracker.sv
// Per-master read-ordering tracker: queues the slave index of each accepted
// ordered AR and grants R returns to the s2m mux strictly in issue order.
module axi_r_order_tracker #(
    parameter int DEPTH = 8,
    parameter int W_CNT = $clog2(DEPTH) + 1
) (
    input  logic             AXI_CLK,
    input  logic             AXI_RSTn,
    input  logic             AR_VALID,
    input  logic             AR_READY,
    input  logic [1:0]       AR_SEL,
    input  logic             R_VALID,
    input  logic             R_READY,
    input  logic             R_LAST,
    input  logic [1:0]       R_SRC,
    output logic [2:0]       r_order_grant,
    output logic             ar_full,
    output logic             ar_empty,
    output logic [W_CNT-1:0] outstanding,
    output logic             err_overflow,
    output logic             err_order
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [W_CNT-1:0] count;
    logic [W_CNT-1:0] count_nxt;
    logic [1:0]       head;
    logic             full;
    logic             empty;
    logic             push_req;
    logic             cpl;
    logic             push;
    logic             pop;

    assign head  = mem[rd_ptr];
    assign full  = (count == W_CNT'(DEPTH));
    assign empty = (count == '0);

    assign push_req = AR_VALID & AR_READY & (AR_SEL != 2'd3);
    assign cpl      = R_VALID & R_READY & R_LAST & (R_SRC != 2'd3);
    assign pop      = cpl & ~empty & (R_SRC == head);
    // A same-cycle pop frees the slot, so a push at full is still accepted.
    assign push     = push_req & (~full | pop);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + W_CNT'(1);
            2'b01:   count_nxt = count - W_CNT'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge AXI_CLK) begin
        if (push) begin
            mem[wr_ptr] <= AR_SEL;
        end
    end

    always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
        if (!AXI_RSTn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
            err_order    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            if (push_req && full && !pop) begin
                err_overflow <= 1'b1;
            end
            if (cpl && !pop) begin
                err_order <= 1'b1;
            end
        end
    end

    // Grant decodes only registered state so the mux sees no input-to-output path.
    always_comb begin
        r_order_grant = 3'b000;
        if (!empty) begin
            case (head)
                2'd0:    r_order_grant = 3'b001;
                2'd1:    r_order_grant = 3'b010;
                2'd2:    r_order_grant = 3'b100;
                default: r_order_grant = 3'b000;
            endcase
        end
    end

    assign ar_full     = full;
    assign ar_empty    = empty;
    assign outstanding = count;

endmodule

// File: tb/tb_axi_r_order_tracker.sv
// Directed testbench for axi_r_order_tracker (DEPTH=8).
module tb_axi_r_order_tracker;

    localparam int DEPTH = 8;
    localparam int W_CNT = 4;

    logic             clk;
    logic             rst_n;
    logic             ar_valid;
    logic             ar_ready;
    logic [1:0]       ar_sel;
    logic             r_valid;
    logic             r_ready;
    logic             r_last;
    logic [1:0]       r_src;
    logic [2:0]       grant;
    logic             full;
    logic             empty;
    logic [W_CNT-1:0] outst;
    logic             e_ovf;
    logic             e_ord;

    int n_cmp = 0;
    int n_err = 0;

    axi_r_order_tracker #(.DEPTH(DEPTH), .W_CNT(W_CNT)) dut (
        .AXI_CLK       (clk),
        .AXI_RSTn      (rst_n),
        .AR_VALID      (ar_valid),
        .AR_READY      (ar_ready),
        .AR_SEL        (ar_sel),
        .R_VALID       (r_valid),
        .R_READY       (r_ready),
        .R_LAST        (r_last),
        .R_SRC         (r_src),
        .r_order_grant (grant),
        .ar_full       (full),
        .ar_empty      (empty),
        .outstanding   (outst),
        .err_overflow  (e_ovf),
        .err_order     (e_ord)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive AR and/or R, step past the edge, return inputs to idle.
    task automatic cyc(input logic av, input logic [1:0] as,
                       input logic rv, input logic rl, input logic [1:0] rs);
        ar_valid = av; ar_ready = av; ar_sel = as;
        r_valid = rv; r_ready = rv; r_last = rl; r_src = rs;
        @(posedge clk); #1;
        ar_valid = 1'b0; ar_ready = 1'b0; ar_sel = 2'd0;
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0; r_src = 2'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL reset_grant: got %b want 000", grant); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (outst !== 4'd0) begin n_err++; $display("FAIL reset_outst: got %0d want 0", outst); end
        n_cmp++; if (e_ovf !== 1'b0 || e_ord !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b%b want 00", e_ovf, e_ord); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_in_order();
        cyc(1, 2'd2, 0, 0, 2'd0);
        n_cmp++; if (grant !== 3'b100) begin n_err++; $display("FAIL order_first_grant: got %b want 100", grant); end
        cyc(1, 2'd0, 0, 0, 2'd0);
        cyc(1, 2'd1, 0, 0, 2'd0);
        n_cmp++; if (outst !== 4'd3) begin n_err++; $display("FAIL order_outst: got %0d want 3", outst); end
        cyc(0, 2'd0, 1, 0, 2'd2);
        n_cmp++; if (grant !== 3'b100) begin n_err++; $display("FAIL order_nonlast: got %b want 100", grant); end
        cyc(0, 2'd0, 1, 1, 2'd2);
        n_cmp++; if (grant !== 3'b001) begin n_err++; $display("FAIL order_after_s2: got %b want 001", grant); end
        cyc(0, 2'd0, 1, 0, 2'd0);
        cyc(0, 2'd0, 1, 1, 2'd0);
        n_cmp++; if (grant !== 3'b010) begin n_err++; $display("FAIL order_after_s0: got %b want 010", grant); end
        cyc(0, 2'd0, 1, 1, 2'd1);
        n_cmp++; if (grant !== 3'b000 || empty !== 1'b1) begin n_err++; $display("FAIL order_drained: got grant %b empty %b want 000 1", grant, empty); end
        n_cmp++; if (e_ord !== 1'b0) begin n_err++; $display("FAIL order_no_err: got %b want 0", e_ord); end
    endtask

    task automatic test_sd_bypass();
        cyc(1, 2'd1, 0, 0, 2'd0);
        cyc(1, 2'd3, 0, 0, 2'd0);
        cyc(1, 2'd0, 0, 0, 2'd0);
        n_cmp++; if (outst !== 4'd2) begin n_err++; $display("FAIL sd_outst: got %0d want 2", outst); end
        cyc(0, 2'd0, 1, 1, 2'd3);
        n_cmp++; if (outst !== 4'd2 || e_ord !== 1'b0) begin n_err++; $display("FAIL sd_rlast: got outst %0d err %b want 2 0", outst, e_ord); end
        n_cmp++; if (grant !== 3'b010) begin n_err++; $display("FAIL sd_grant: got %b want 010", grant); end
        cyc(0, 2'd0, 1, 1, 2'd1);
        n_cmp++; if (grant !== 3'b001) begin n_err++; $display("FAIL sd_after_s1: got %b want 001", grant); end
        cyc(0, 2'd0, 1, 1, 2'd0);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL sd_drained: got %b want 1", empty); end
    endtask

    task automatic test_full_wrap();
        logic [1:0] exp_q[$];
        logic [2:0] want;
        logic [1:0] h;
        for (int unsigned i = 0; i < 8; i++) begin
            cyc(1, 2'(i % 3), 0, 0, 2'd0);
            exp_q.push_back(2'(i % 3));
            if (i == 6) begin
                n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL full_early: got %b want 0", full); end
            end
        end
        n_cmp++; if (full !== 1'b1 || outst !== 4'd8) begin n_err++; $display("FAIL full_set: got full %b outst %0d want 1 8", full, outst); end
        cyc(1, 2'd2, 0, 0, 2'd0);
        n_cmp++; if (e_ovf !== 1'b1 || outst !== 4'd8) begin n_err++; $display("FAIL overflow: got err %b outst %0d want 1 8", e_ovf, outst); end
        // Push and pop together at full for 8 cycles, then drain: 16 pops across wrap.
        for (int unsigned i = 0; i < 8; i++) begin
            h = exp_q.pop_front();
            want = 3'b001 << h;
            n_cmp++; if (grant !== want) begin n_err++; $display("FAIL wrap_pp_grant[%0d]: got %b want %b", i, grant, want); end
            cyc(1, 2'((i + 2) % 3), 1, 1, h);
            exp_q.push_back(2'((i + 2) % 3));
            n_cmp++; if (outst !== 4'd8 || full !== 1'b1) begin n_err++; $display("FAIL wrap_pp_outst[%0d]: got %0d full %b want 8 1", i, outst, full); end
        end
        for (int unsigned i = 0; i < 8; i++) begin
            h = exp_q.pop_front();
            want = 3'b001 << h;
            n_cmp++; if (grant !== want) begin n_err++; $display("FAIL wrap_drain_grant[%0d]: got %b want %b", i, grant, want); end
            cyc(0, 2'd0, 1, 1, h);
        end
        n_cmp++; if (empty !== 1'b1 || grant !== 3'b000) begin n_err++; $display("FAIL wrap_empty: got empty %b grant %b want 1 000", empty, grant); end
        n_cmp++; if (e_ord !== 1'b0) begin n_err++; $display("FAIL wrap_no_order_err: got %b want 0", e_ord); end
    endtask

    task automatic test_order_violation();
        cyc(1, 2'd0, 0, 0, 2'd0);
        cyc(1, 2'd1, 0, 0, 2'd0);
        cyc(0, 2'd0, 1, 1, 2'd1);
        n_cmp++; if (e_ord !== 1'b1) begin n_err++; $display("FAIL viol_err: got %b want 1", e_ord); end
        n_cmp++; if (outst !== 4'd2 || grant !== 3'b001) begin n_err++; $display("FAIL viol_nopop: got outst %0d grant %b want 2 001", outst, grant); end
        cyc(0, 2'd0, 1, 1, 2'd0);
        cyc(0, 2'd0, 1, 1, 2'd1);
        n_cmp++; if (empty !== 1'b1 || e_ord !== 1'b1) begin n_err++; $display("FAIL viol_drain: got empty %b err %b want 1 1", empty, e_ord); end
    endtask

    task automatic test_reset_midstream();
        for (int unsigned i = 0; i < 5; i++) cyc(1, 2'(i % 3), 0, 0, 2'd0);
        n_cmp++; if (outst !== 4'd5) begin n_err++; $display("FAIL mid_pre: got %0d want 5", outst); end
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (outst !== 4'd0 || grant !== 3'b000) begin n_err++; $display("FAIL mid_async: got outst %0d grant %b want 0 000", outst, grant); end
        n_cmp++; if (e_ovf !== 1'b0 || e_ord !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL mid_flags: got ovf %b ord %b empty %b want 0 0 1", e_ovf, e_ord, empty); end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1, 2'd2, 0, 0, 2'd0);
        n_cmp++; if (grant !== 3'b100 || outst !== 4'd1) begin n_err++; $display("FAIL mid_resume: got grant %b outst %0d want 100 1", grant, outst); end
        cyc(0, 2'd0, 1, 1, 2'd2);
        n_cmp++; if (empty !== 1'b1 || e_ord !== 1'b0) begin n_err++; $display("FAIL mid_resume_pop: got empty %b err %b want 1 0", empty, e_ord); end
    endtask

    task automatic test_empty_completion();
        cyc(1, 2'd1, 1, 1, 2'd0);
        n_cmp++; if (e_ord !== 1'b1) begin n_err++; $display("FAIL empty_cpl_err: got %b want 1", e_ord); end
        n_cmp++; if (outst !== 4'd1 || grant !== 3'b010) begin n_err++; $display("FAIL empty_cpl_push: got outst %0d grant %b want 1 010", outst, grant); end
        n_cmp++; if (e_ovf !== 1'b0) begin n_err++; $display("FAIL empty_cpl_ovf: got %b want 0", e_ovf); end
    endtask

    initial begin
        ar_valid = 1'b0; ar_ready = 1'b0; ar_sel = 2'd0;
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0; r_src = 2'd0;
        rst_n = 1'b1;
        #2;
        test_reset();
        test_in_order();
        test_sd_bypass();
        test_full_wrap();
        test_order_violation();
        test_reset_midstream();
        test_empty_completion();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_r_order_tracker.md
# axi_r_order_tracker

Per-master read-ordering tracker. It records, in issue order, which slave each accepted read address was sent to. It then drives the `r_order_grant` mask into the master-side read-response mux (`axi_s2m_s3`), so R bursts from slaves S0–S2 reach the master strictly in AR issue order. Default-slave (SD) traffic is not ordered, because the mux always admits SD. The block sits beside the master's AR decode path and in front of that mux's `r_order_grant` input.

## Interface

Parameters:
- `DEPTH`, default 8: maximum outstanding ordered reads; power of two, ≥2.
- `W_CNT`, default `$clog2(DEPTH)+1`: width of the occupancy count.

Ports:
- `AXI_CLK`  in  1  clock; all state on rising edge.
- `AXI_RSTn`  in  1  reset, asynchronous, active-low.
- `AR_VALID`  in  1  master AR valid, observed after the address decoder.
- `AR_READY`  in  1  master AR ready, observed after gating with `ar_full`.
- `AR_SEL`  in  2  decoded target of the AR: 0/1/2 = S0/S1/S2, 3 = SD.
- `R_VALID`  in  1  `M_RVALID` from the s2m mux.
- `R_READY`  in  1  `M_RREADY` from the master.
- `R_LAST`  in  1  `M_RLAST` from the s2m mux.
- `R_SRC`  in  2  index of the slave currently granted by the s2m mux (0/1/2, 3 = SD).
- `r_order_grant`  out  3  one-hot mask of the slave allowed to return R; feeds the s2m mux.
- `ar_full`  out  1  queue holds DEPTH entries; upstream must drop AR_READY.
- `ar_empty`  out  1  no ordered read outstanding.
- `outstanding`  out  W_CNT  number of queued entries, 0..DEPTH.
- `err_overflow`  out  1  sticky: push attempted while full.
- `err_order`  out  1  sticky: ordered burst completed out of order or while empty.

## Operation

- Storage is a circular FIFO of DEPTH 2-bit slave indices.
  - Pointers `wr_ptr` and `rd_ptr` are each `$clog2(DEPTH)` bits and wrap modulo DEPTH.
  - `count` is W_CNT bits.
- Push occurs when `AR_VALID & AR_READY & (AR_SEL != 3)`.
  - If not full: write `AR_SEL` at `wr_ptr`, then increment `wr_ptr`.
  - If full: no write, and `err_overflow` is set.
- SD reads (`AR_SEL==3`) are never pushed.
- A completion event occurs when `R_VALID & R_READY & R_LAST & (R_SRC != 3)`.
  - If not empty and `R_SRC == head`: pop, which increments `rd_ptr`.
  - If empty, or if `R_SRC != head`: no pop, and `err_order` is set.
- Non-last beats and SD beats never pop.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop occur in the same cycle, including at `count==DEPTH` (see below).
- Full condition when push and pop coincide:
  - A pop in the same cycle frees the slot, so the push is accepted.
  - `err_overflow` is not set in this case.
- `r_order_grant`:
  - Value is `1 << head` when not empty; `3'b000` when empty.
  - Decoded only from registered state (head entry and count), with no combinational path from any input.
  - The head entry is never 3.
- `ar_full = (count == DEPTH)`; `ar_empty = (count == 0)`; `outstanding = count`.
- The error flags are sticky and cleared only by reset.

## Timing

- Reset (asynchronous assert, synchronous-release use):
  - Pointers and count become 0; memory contents are don't-care.
  - Outputs: `r_order_grant = 3'b000`, `ar_full = 0`, `ar_empty = 1`, `outstanding = 0`, `err_overflow = 0`, `err_order = 0`.
- Reset mid-operation discards all queued entries immediately. Outputs take their reset values without waiting for a clock edge.
- Push latency: an AR accepted at edge N makes its grant visible after edge N, i.e. in cycle N+1 when the queue was empty.
- Pop latency: an RLAST accepted at edge N advances `r_order_grant` to the next entry in cycle N+1. This allows back-to-back bursts from different slaves with no bubble beyond the mux's own arbitration.
- Simultaneous push and pop on an empty queue cannot occur, because a pop needs a head. The completion flags `err_order`; the push is accepted.
- `ar_full` rises the cycle after the DEPTH-th push. Upstream gating of AR_READY is the only backpressure, and this block never stalls R.

## Test plan

- Reset check:
  - Drive `AXI_RSTn=0`.
  - Expect `r_order_grant=000`, `ar_empty=1`, `outstanding=0`, both error flags 0.
- In-order release across slaves:
  - Push ARs to S2, S0, S1.
  - Expect grant `100`, then `001` after the S2 RLAST, then `010` after the S0 RLAST, then `000` with `ar_empty=1` after the S1 RLAST.
  - Non-last beats leave the grant unchanged.
- SD bypass:
  - Push S1, then an SD AR (`AR_SEL=3`), then S0.
  - Expect `outstanding=2`.
  - An SD RLAST (`R_SRC=3`) causes no pop and no error.
  - Grant stays `010` until the S1 RLAST.
- Full and wrap-around (DEPTH=8):
  - Push 8 ARs; expect `ar_full=1`, `outstanding=8`.
  - Push a 9th without a pop; expect `err_overflow=1` and `outstanding` still 8.
  - Push and pop in the same cycle at full; expect `outstanding=8`, no new error.
  - Drain 16 entries across the pointer wrap; expect order preserved.
- Order violation:
  - With head=S0, complete an S1 burst (`R_SRC=1`, `R_LAST=1`).
  - Expect `err_order=1`, no pop, grant still `001`.
- Reset mid-stream:
  - With 5 entries queued, pulse `AXI_RSTn` low for a fraction of a cycle.
  - Expect `outstanding=0` and `r_order_grant=000` immediately.
  - Expect normal operation on the next push.
